uart_tx_core: RTL and testbench

Serial UART transmitter for the memory-mapped UART peripheral. It is the transmit-side counterpart of the receive path and its error logic. The LSU writes a byte into a one-deep holding register, and the block frames and shifts it out LSB-first with optional parity and one or two stop bits. It reports holding-register full, busy, frame-done and a sticky write-overflow flag to the UART status register.

---
 rtl/uart_tx_core.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_core.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// uart_tx_core: UART transmitter with a one-deep holding register.
// A byte written by the LSU waits in the holding register. It is then framed
// as start, DATA_BITS data bits LSB-first, optional parity, and one or two
// stop bits, and shifted out on a registered serial line.
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   tx_wdata     byte to transmit
//   tx_we        one-cycle write strobe
//   baud_div     clock cycles per serial bit (0 behaves as 1)
//   parity_en    append parity bit after data
//   parity_odd   1 = odd parity, 0 = even parity
//   two_stop     1 = two stop bits, 0 = one stop bit
//   clr_err      clears tx_overflow
//   tx           serial line, idle high
//   TxFF         holding register full
//   tx_busy      frame in progress
//   tx_done      one-cycle pulse after the last stop bit
//   tx_overflow  sticky: a write was dropped because TxFF was set
module uart_tx_core #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_wdata,
  input  logic                 tx_we,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  input  logic                 clr_err,
  output logic                 tx,
  output logic                 TxFF,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx_overflow
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam int unsigned       IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic [2:0]           state;
  logic [DATA_BITS-1:0] hold;
  logic [DATA_BITS-1:0] shifter;
  logic [DATA_BITS-1:0] shift_next;
  logic [IDX_W-1:0]     bit_idx;
  logic [DIV_W-1:0]     bit_cnt;
  logic [DIV_W-1:0]     cfg_div_m1;
  logic [DIV_W-1:0]     div_m1;
  logic                 cfg_par_en;
  logic                 cfg_two_stop;
  logic                 par_bit;
  logic                 stop_second;
  logic                 bit_end;
  logic                 stop_end;
  logic                 load;

  always_comb begin
    div_m1     = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
    bit_end    = (bit_cnt == '0);
    stop_end   = (state == S_STOP) && bit_end && (!cfg_two_stop || stop_second);
    // A frame is loaded from the holding register either from an idle line
    // or on the very edge that ends the last stop bit (no idle gap).
    load       = TxFF && ((state == S_IDLE) || stop_end);
    shift_next = shifter >> 1;
  end

  assign tx_busy = (state != S_IDLE);

  // Holding register and overflow flag. Acceptance needs TxFF=0 and a load
  // needs TxFF=1, so the two never collide; a write on a load edge is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold        <= '0;
      TxFF        <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      if (tx_we && !TxFF) begin
        hold <= tx_wdata;
        TxFF <= 1'b1;
      end else if (load) begin
        TxFF <= 1'b0;
      end
      if (tx_we && TxFF) begin
        tx_overflow <= 1'b1;
      end else if (clr_err) begin
        tx_overflow <= 1'b0;
      end
    end
  end

  // Frame sequencer. Line config is captured at load so that mid-frame
  // register writes cannot corrupt the frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      tx           <= 1'b1;
      tx_done      <= 1'b0;
      shifter      <= '0;
      bit_idx      <= '0;
      bit_cnt      <= '0;
      cfg_div_m1   <= '0;
      cfg_par_en   <= 1'b0;
      cfg_two_stop <= 1'b0;
      par_bit      <= 1'b0;
      stop_second  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (load) begin
        state        <= S_START;
        tx           <= 1'b0;
        shifter      <= hold;
        par_bit      <= (^hold) ^ parity_odd;
        cfg_par_en   <= parity_en;
        cfg_two_stop <= two_stop;
        cfg_div_m1   <= div_m1;
        bit_cnt      <= div_m1;
        if (stop_end) begin
          tx_done <= 1'b1;
        end
      end else if (state != S_IDLE) begin
        if (!bit_end) begin
          bit_cnt <= bit_cnt - DIV_W'(1);
        end else begin
          bit_cnt <= cfg_div_m1;
          case (state)
            S_START: begin
              state   <= S_DATA;
              tx      <= shifter[0];
              bit_idx <= '0;
            end
            S_DATA: begin
              if (bit_idx == LAST_IDX) begin
                if (cfg_par_en) begin
                  state <= S_PARITY;
                  tx    <= par_bit;
                end else begin
                  state       <= S_STOP;
                  tx          <= 1'b1;
                  stop_second <= 1'b0;
                end
              end else begin
                shifter <= shift_next;
                tx      <= shift_next[0];
                bit_idx <= bit_idx + IDX_W'(1);
              end
            end
            S_PARITY: begin
              state       <= S_STOP;
              tx          <= 1'b1;
              stop_second <= 1'b0;
            end
            S_STOP: begin
              if (stop_end) begin
                tx_done <= 1'b1;
                state   <= S_IDLE;
                tx      <= 1'b1;
              end else begin
                stop_second <= 1'b1;
              end
            end
            default: begin
              state <= S_IDLE;
              tx    <= 1'b1;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: directed bench for uart_tx_core with a frame-level model
// (expected line value per cycle held in a queue) checked every cycle, plus
// literal waveform expectations per scenario.
module tb_uart_tx_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  tx_wdata = '0;
  logic        tx_we = 1'b0;
  logic [15:0] baud_div = 16'd4;
  logic        parity_en = 1'b0;
  logic        parity_odd = 1'b0;
  logic        two_stop = 1'b0;
  logic        clr_err = 1'b0;
  logic        tx, TxFF, tx_busy, tx_done, tx_overflow;

  uart_tx_core #(.DATA_BITS(8), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .tx_wdata(tx_wdata), .tx_we(tx_we),
    .baud_div(baud_div), .parity_en(parity_en), .parity_odd(parity_odd),
    .two_stop(two_stop), .clr_err(clr_err), .tx(tx), .TxFF(TxFF),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_overflow(tx_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, exp);
    end
  endtask

  // Model: each frame is expanded into the per-cycle line values it must
  // produce; one entry is consumed per clock edge.
  bit       mq[$];
  bit       m_full, m_ovf, m_done, m_old_full, m_load;
  bit [7:0] m_hold;

  function automatic void build_frame(input bit [7:0] d);
    int unsigned bt;
    bit p;
    bt = (baud_div == 0) ? 1 : baud_div;
    p  = (^d) ^ parity_odd;
    for (int unsigned k = 0; k < bt; k++) mq.push_back(1'b0);
    for (int unsigned b = 0; b < 8; b++)
      for (int unsigned k = 0; k < bt; k++) mq.push_back(d[b]);
    if (parity_en)
      for (int unsigned k = 0; k < bt; k++) mq.push_back(p);
    for (int unsigned k = 0; k < bt * (two_stop ? 2 : 1); k++) mq.push_back(1'b1);
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_full = 0; m_ovf = 0; m_done = 0; mq.delete();
    end else begin
      m_old_full = m_full;
      m_load = 0;
      m_done = 0;
      if (mq.size() != 0) begin
        void'(mq.pop_front());
        if (mq.size() == 0) begin
          m_done = 1;
          m_load = m_old_full;
        end
      end else begin
        m_load = m_old_full;
      end
      if (tx_we && m_old_full) m_ovf = 1;
      else if (clr_err) m_ovf = 0;
      if (m_load) begin
        build_frame(m_hold);
        m_full = 0;
      end
      if (tx_we && !m_old_full) begin
        m_hold = tx_wdata;
        m_full = 1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst && chk_en) begin
      chk("tx",      64'(tx),          64'((mq.size() != 0) ? mq[0] : 1'b1));
      chk("busy",    64'(tx_busy),     64'(mq.size() != 0));
      chk("done",    64'(tx_done),     64'(m_done));
      chk("TxFF",    64'(TxFF),        64'(m_full));
      chk("ovf",     64'(tx_overflow), 64'(m_ovf));
    end
  end

  // Stimulus tables: entry i is driven before edge i; sample i is taken
  // after edge i.
  bit          we_tab[64];
  bit [7:0]    wd_tab[64];
  bit          clr_tab[64];
  int          flip_at;
  logic [63:0] cap_tx, cap_done, cap_full, cap_ovf, cap_busy;

  task automatic clear_tabs();
    for (int i = 0; i < 64; i++) begin
      we_tab[i] = 0; wd_tab[i] = '0; clr_tab[i] = 0;
    end
    flip_at = -1;
  endtask

  task automatic run_capture(input int n);
    cap_tx = '0; cap_done = '0; cap_full = '0; cap_ovf = '0; cap_busy = '0;
    for (int i = 0; i < n; i++) begin
      tx_we    = we_tab[i];
      tx_wdata = wd_tab[i];
      clr_err  = clr_tab[i];
      if (i == flip_at) begin
        parity_odd = ~parity_odd;
        baud_div   = 16'd3;
      end
      @(negedge clk);
      cap_tx[i]   = tx;
      cap_done[i] = tx_done;
      cap_full[i] = TxFF;
      cap_ovf[i]  = tx_overflow;
      cap_busy[i] = tx_busy;
    end
    tx_we   = 0;
    clr_err = 0;
  endtask

  task automatic wait_idle();
    int unsigned k;
    k = 0;
    while ((tx_busy || TxFF) && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", 64'(k < 300), 64'd1);
    @(negedge clk);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_tx",   64'(tx),          64'd1);
    chk("rst_full", 64'(TxFF),        64'd0);
    chk("rst_busy", 64'(tx_busy),     64'd0);
    chk("rst_done", 64'(tx_done),     64'd0);
    chk("rst_ovf",  64'(tx_overflow), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // 8N1 at 4 cycles/bit, 0x55
    baud_div = 16'd4; parity_en = 0; parity_odd = 0; two_stop = 0;
    clear_tabs(); we_tab[0] = 1; wd_tab[0] = 8'h55;
    run_capture(44);
    chk("t1_full_after_write", 64'(cap_full[0]), 64'd1);
    chk("t1_full_after_load",  64'(cap_full[1]), 64'd0);
    chk("t1_wave",  64'(cap_tx[40:1]), 64'h00F0F0F0F0F0);
    chk("t1_idle",  64'(cap_tx[41]),   64'd1);
    chk("t1_done",  cap_done,          64'd1 << 41);
    chk("t1_busy_last", 64'(cap_busy[40]), 64'd1);
    chk("t1_busy_end",  64'(cap_busy[41]), 64'd0);
    wait_idle();

    // 8E1 at 2 cycles/bit, 0x07: even parity bit is 1
    baud_div = 16'd2; parity_en = 1; parity_odd = 0;
    clear_tabs(); we_tab[0] = 1; wd_tab[0] = 8'h07;
    run_capture(24);
    chk("t2_even_wave", 64'(cap_tx[22:1]), 64'h3C00FC);
    chk("t2_even_done", cap_done, 64'd1 << 23);
    wait_idle();

    // 8O1, with a config change mid-frame that must not affect it
    parity_odd = 1;
    clear_tabs(); we_tab[0] = 1; wd_tab[0] = 8'h07; flip_at = 5;
    run_capture(24);
    chk("t2_odd_wave", 64'(cap_tx[22:1]), 64'h3000FC);
    chk("t2_odd_done", cap_done, 64'd1 << 23);
    wait_idle();

    // Two-byte burst at 1 cycle/bit, contiguous frames
    baud_div = 16'd1; parity_en = 0; parity_odd = 0; two_stop = 0;
    clear_tabs();
    we_tab[0] = 1; wd_tab[0] = 8'hA5;
    we_tab[2] = 1; wd_tab[2] = 8'h3C;
    run_capture(26);
    chk("t3_wave", 64'(cap_tx[20:1]), 64'h9E34A);
    chk("t3_done", cap_done, 64'h200800);
    chk("t3_ovf",  cap_ovf,  64'd0);
    wait_idle();

    // Overflow: third write dropped; clr_err; same-edge set wins
    clear_tabs();
    we_tab[0] = 1; wd_tab[0] = 8'h11;
    we_tab[2] = 1; wd_tab[2] = 8'h22;
    we_tab[3] = 1; wd_tab[3] = 8'hFF;
    clr_tab[5] = 1;
    we_tab[7] = 1; wd_tab[7] = 8'hEE; clr_tab[7] = 1;
    clr_tab[9] = 1;
    run_capture(24);
    chk("t4_ovf",   64'(cap_ovf[10:0]),  64'h198);
    chk("t4_data2", 64'(cap_tx[19:12]),  64'h22);
    chk("t4_done",  cap_done,            64'h200800);
    wait_idle();

    // Reset in the middle of the data bits of 0xFF
    baud_div = 16'd4;
    clear_tabs(); we_tab[0] = 1; wd_tab[0] = 8'hFF;
    run_capture(22);
    chk("t5_pre_busy", 64'(tx_busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_tx",   64'(tx),      64'd1);
    chk("t5_rst_full", 64'(TxFF),    64'd0);
    chk("t5_rst_busy", 64'(tx_busy), 64'd0);
    chk("t5_rst_done", 64'(tx_done), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_tabs();
    run_capture(6);
    chk("t5_quiet_tx",   64'(cap_tx[5:0]), 64'h3F);
    chk("t5_quiet_done", cap_done,         64'd0);
    baud_div = 16'd1;
    clear_tabs(); we_tab[0] = 1; wd_tab[0] = 8'h3C;
    run_capture(14);
    chk("t5_after_wave", 64'(cap_tx[10:1]), 64'h278);
    chk("t5_after_done", cap_done,          64'h800);
    wait_idle();

    // baud_div=0 behaves as 1, two stop bits, 0x00
    baud_div = 16'd0; two_stop = 1;
    clear_tabs(); we_tab[0] = 1; wd_tab[0] = 8'h00;
    run_capture(15);
    chk("t6_wave", 64'(cap_tx[11:1]), 64'h600);
    chk("t6_idle", 64'(cap_tx[12]),   64'd1);
    chk("t6_done", cap_done,          64'h1000);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
